// File: rtl/tx_ffe_tap_adapter.sv
// Sign-sign hill climb on the TX FFE post-cursor tap code, driven by
// eye-opening measurements from the RX-side eye calculator.
module tx_ffe_tap_adapter #(
  parameter int  CODE_W    = 5,
  parameter int  INIT_CODE = 4,
  parameter real TAP_LSB   = 0.05,
  parameter int  DISCARD   = 1,
  parameter real HYST      = 0.0,
  parameter int  MAX_REV   = 2,
  parameter int  MAX_ITERS = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  real               opening,
  input  logic              opening_ready,
  input  logic              restart,
  output logic [CODE_W-1:0] tap_code,
  output real               tap_weight,
  output logic              code_update,
  output real               best_opening,
  output logic              adapt_done
);

  typedef enum logic [1:0] {
    SETTLE,
    MEASURE,
    DECIDE,
    DONE
  } state_t;

  localparam int NW = CODE_W + 2;
  localparam logic [CODE_W-1:0] INIT = CODE_W'(INIT_CODE);

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] best_code_q, best_code_d;
  logic              dir_up_q, dir_up_d;
  logic [7:0]        rev_q, rev_d;
  logic [15:0]       iters_q, iters_d;
  logic [7:0]        disc_q, disc_d;
  logic              best_valid_q, best_valid_d;
  logic              upd_q, upd_d;
  real               best_q, best_d;
  real               meas_q, meas_d;

  logic              improve;
  logic [CODE_W-1:0] bc;
  logic              dir1, dir2;
  logic [7:0]        rev1, rev2;
  logic [NW-1:0]     nxt1, nxt2;
  logic              oob1, oob2;
  logic              fin;

  // Extra headroom bits make -1 and 2**CODE_W both show up as high bits set.
  always_comb begin
    improve = !best_valid_q || (meas_q > best_q + HYST);
    bc      = improve ? code_q : best_code_q;
    dir1    = improve ? dir_up_q : !dir_up_q;
    rev1    = improve ? rev_q : rev_q + 8'd1;
    nxt1    = {2'b00, bc} + (dir1 ? NW'(1) : {NW{1'b1}});
    oob1    = |nxt1[NW-1:CODE_W];
    dir2    = oob1 ? !dir1 : dir1;
    rev2    = oob1 ? rev1 + 8'd1 : rev1;
    nxt2    = oob1 ? {2'b00, bc} + (dir2 ? NW'(1) : {NW{1'b1}}) : nxt1;
    oob2    = oob1 && (|nxt2[NW-1:CODE_W]);
    fin     = (rev2 >= 8'(MAX_REV)) || (iters_q == 16'(MAX_ITERS)) || oob2;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SETTLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SETTLE: begin
        if (DISCARD == 0 ||
            (opening_ready && int'(disc_q) + 1 >= DISCARD))
          state_d = MEASURE;
      end
      MEASURE: if (opening_ready) state_d = DECIDE;
      DECIDE:  state_d = fin ? DONE : SETTLE;
      DONE:    if (restart) state_d = SETTLE;
    endcase
  end

  always_comb begin
    code_d       = code_q;
    best_code_d  = best_code_q;
    dir_up_d     = dir_up_q;
    rev_d        = rev_q;
    iters_d      = iters_q;
    disc_d       = disc_q;
    best_valid_d = best_valid_q;
    best_d       = best_q;
    meas_d       = meas_q;
    upd_d        = 1'b0;
    unique case (state_q)
      SETTLE: if (opening_ready) disc_d = disc_q + 8'd1;
      MEASURE: begin
        if (opening_ready) begin
          meas_d  = opening;
          iters_d = iters_q + 16'd1;
        end
      end
      DECIDE: begin
        best_d       = improve ? meas_q : best_q;
        best_code_d  = bc;
        best_valid_d = 1'b1;
        dir_up_d     = dir2;
        rev_d        = rev2;
        code_d       = fin ? bc : nxt2[CODE_W-1:0];
        disc_d       = 8'd0;
        upd_d        = (code_d != code_q);
      end
      DONE: begin
        if (restart) begin
          code_d       = INIT;
          dir_up_d     = 1'b1;
          rev_d        = 8'd0;
          iters_d      = 16'd0;
          disc_d       = 8'd0;
          best_valid_d = 1'b0;
          best_d       = 0.0;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      code_q       <= INIT;
      best_code_q  <= INIT;
      dir_up_q     <= 1'b1;
      rev_q        <= 8'd0;
      iters_q      <= 16'd0;
      disc_q       <= 8'd0;
      best_valid_q <= 1'b0;
      upd_q        <= 1'b0;
      best_q       <= 0.0;
      meas_q       <= 0.0;
    end else begin
      code_q       <= code_d;
      best_code_q  <= best_code_d;
      dir_up_q     <= dir_up_d;
      rev_q        <= rev_d;
      iters_q      <= iters_d;
      disc_q       <= disc_d;
      best_valid_q <= best_valid_d;
      upd_q        <= upd_d;
      best_q       <= best_d;
      meas_q       <= meas_d;
    end
  end

  always_comb begin
    tap_code     = code_q;
    tap_weight   = -(real'(code_q)) * TAP_LSB;
    code_update  = upd_q;
    best_opening = best_q;
    adapt_done   = (state_q == DONE);
  end

endmodule

// File: tb/tb_tx_ffe_tap_adapter.sv
// Directed closed-loop bench: eye models drive the adapter, expected
// code sequence is queued and popped on every code_update.
module tb_tx_ffe_tap_adapter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  real        opening = 0.0;
  logic       opening_ready = 1'b0;
  logic       restart = 1'b0;
  logic [4:0] tap_code;
  real        tap_weight;
  logic       code_update;
  real        best_opening;
  logic       adapt_done;

  int checks = 0;
  int passed = 0;
  int exp_q[$];
  bit fresh;
  int n;

  tx_ffe_tap_adapter dut (
    .clock        (clock),
    .reset        (reset),
    .opening      (opening),
    .opening_ready(opening_ready),
    .restart      (restart),
    .tap_code     (tap_code),
    .tap_weight   (tap_weight),
    .code_update  (code_update),
    .best_opening (best_opening),
    .adapt_done   (adapt_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chkr(input string tag, input real obs, input real exp);
    checks++;
    assert (((obs - exp) < 1e-9 && (exp - obs) < 1e-9) === 1'b1) passed++;
    else $error("FAIL %s: observed %f expected %f", tag, obs, exp);
  endtask

  function automatic real eye(input int kind, input int c);
    real rc;
    rc = real'(c);
    case (kind)
      0:       eye = 0.8 - 0.02 * (rc - 7.0) * (rc - 7.0);
      1:       eye = 0.5;
      default: eye = 0.8 - 0.02 * rc;
    endcase
  endfunction

  task automatic observe();
    repeat (3) begin
      @(negedge clock);
      if (code_update) begin
        fresh = 1'b1;
        if (exp_q.size() == 0) chk("spurious_update", int'(tap_code), -1);
        else chk("code_seq", int'(tap_code), exp_q.pop_front());
      end
    end
  endtask

  task automatic pulse(input real v);
    @(negedge clock);
    opening = v;
    opening_ready = 1'b1;
    @(negedge clock);
    opening_ready = 1'b0;
    observe();
  endtask

  // First pulse after any code change carries a bogus 9.9 that must be dropped.
  task automatic run(input int kind, input int stop, output int cnt);
    real v;
    cnt = 0;
    fresh = 1'b1;
    while (!adapt_done && cnt < 100 &&
           !(stop >= 0 && int'(tap_code) == stop)) begin
      v = fresh ? 9.9 : eye(kind, int'(tap_code));
      fresh = 1'b0;
      pulse(v);
      cnt++;
    end
    chk("run_budget", longint'(cnt < 100), 1);
  endtask

  task automatic do_restart();
    @(negedge clock);
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    chk("rst_code", int'(tap_code), 4);
    chkr("rst_best", best_opening, 0.0);
    chk("rst_done", int'(adapt_done), 0);
  endtask

  task automatic concave_run(input string tag);
    exp_q = '{5, 6, 7, 8, 6, 7};
    run(0, -1, n);
    chk({tag, "_pulses"}, n, 12);
    chk({tag, "_code"}, int'(tap_code), 7);
    chkr({tag, "_best"}, best_opening, 0.8);
    chkr({tag, "_weight"}, tap_weight, -0.35);
    chk({tag, "_done"}, int'(adapt_done), 1);
    chk({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("reset_code", int'(tap_code), 4);
    chkr("reset_weight", tap_weight, -0.20);
    chk("reset_done", int'(adapt_done), 0);
    chk("reset_update", int'(code_update), 0);
    chkr("reset_best", best_opening, 0.0);

    concave_run("concave");
    @(negedge clock);
    chk("done_hold", int'(tap_code), 7);

    do_restart();
    exp_q = '{5, 3, 4};
    run(1, -1, n);
    chk("flat_pulses", n, 6);
    chk("flat_code", int'(tap_code), 4);
    chkr("flat_best", best_opening, 0.5);
    chk("flat_q_empty", exp_q.size(), 0);

    do_restart();
    exp_q = '{5, 3, 2, 1, 0};
    run(2, -1, n);
    chk("peak0_pulses", n, 12);
    chk("peak0_code", int'(tap_code), 0);
    chkr("peak0_best", best_opening, 0.8);
    chkr("peak0_weight", tap_weight, 0.0);
    chk("peak0_done", int'(adapt_done), 1);
    chk("peak0_q_empty", exp_q.size(), 0);

    do_restart();
    exp_q = '{5, 6};
    run(0, 6, n);
    chk("mid_code", int'(tap_code), 6);
    chk("mid_q_empty", exp_q.size(), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_code", int'(tap_code), 4);
    chk("mid_rst_done", int'(adapt_done), 0);
    chk("mid_rst_update", int'(code_update), 0);
    chkr("mid_rst_best", best_opening, 0.0);
    concave_run("after_reset");

    do_restart();
    concave_run("rerun");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
